// File: rtl/pipeline_ctrl.sv
// Front-end sequencer: owns the fetch PC and steers the IF/ID and ID/EX pipeline registers
// around data-memory holds, decode hazards, taken branches and instruction-memory misses.
module pipeline_ctrl #(
    parameter logic [31:0] RESET_PC     = 32'h0000_0000,
    parameter logic [3:0]  MAX_STALL    = 4'd8,
    parameter logic [1:0]  FLUSH_CYCLES = 2'd1
) (
    input  logic        i_clk,
    input  logic        i_rst,
    input  logic        i_hazard_stall,
    input  logic        i_b_taken,
    input  logic [31:0] i_b_pc,
    input  logic        i_imem_ready,
    input  logic        i_dmem_busy,
    output logic [31:0] pc,
    output logic        if_id_en,
    output logic        if_id_flush,
    output logic        id_ex_bubble,
    output logic        pipe_hold,
    output logic        stall_err,
    output logic [1:0]  state
);

    typedef enum logic [1:0] {
        ST_BOOT  = 2'd0,
        ST_RUN   = 2'd1,
        ST_STALL = 2'd2,
        ST_FLUSH = 2'd3
    } state_e;

    state_e      state_q, state_d;
    logic [31:0] pc_q, pc_d;
    logic [3:0]  stall_cnt_q, stall_cnt_d;
    logic [1:0]  flush_cnt_q, flush_cnt_d;
    logic        stall_err_q, stall_err_d;
    logic [4:0]  stall_inc_s;

    // State register with asynchronous active-low reset
    always_ff @(posedge i_clk or negedge i_rst) begin
        if (!i_rst) begin
            state_q     <= ST_BOOT;
            pc_q        <= RESET_PC;
            stall_cnt_q <= 4'd0;
            flush_cnt_q <= 2'd0;
            stall_err_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            pc_q        <= pc_d;
            stall_cnt_q <= stall_cnt_d;
            flush_cnt_q <= flush_cnt_d;
            stall_err_q <= stall_err_d;
        end
    end

    // Next-state and pipeline-control decode; request priority is fixed by the nesting order
    always_comb begin
        state_d      = state_q;
        pc_d         = pc_q;
        stall_cnt_d  = stall_cnt_q;
        flush_cnt_d  = flush_cnt_q;
        stall_err_d  = stall_err_q;
        if_id_en     = 1'b0;
        if_id_flush  = 1'b0;
        id_ex_bubble = 1'b0;
        pipe_hold    = 1'b0;
        stall_inc_s  = {1'b0, stall_cnt_q} + 5'd1;

        case (state_q)
            ST_BOOT: begin
                if_id_en    = 1'b1;
                if_id_flush = 1'b1;
                state_d     = ST_RUN;
            end
            ST_RUN, ST_STALL: begin
                if (i_dmem_busy) begin
                    pipe_hold = 1'b1;
                end else if (i_hazard_stall) begin
                    // Branch operands are stale while stalled, so a concurrent i_b_taken is dropped
                    id_ex_bubble = 1'b1;
                    state_d      = ST_STALL;
                    if (stall_cnt_q == 4'd15) begin
                        stall_cnt_d = 4'd15;
                    end else begin
                        stall_cnt_d = stall_cnt_q + 4'd1;
                    end
                    if (stall_inc_s == {1'b0, MAX_STALL}) begin
                        stall_err_d = 1'b1;
                    end else begin
                        stall_err_d = stall_err_q;
                    end
                end else begin
                    stall_cnt_d = 4'd0;
                    if_id_en    = 1'b1;
                    if (i_b_taken) begin
                        if_id_flush = 1'b1;
                        pc_d        = {i_b_pc[31:2], 2'b00};
                        if (FLUSH_CYCLES == 2'd1) begin
                            state_d = ST_RUN;
                        end else begin
                            state_d     = ST_FLUSH;
                            flush_cnt_d = FLUSH_CYCLES - 2'd1;
                        end
                    end else if (!i_imem_ready) begin
                        if_id_flush = 1'b1;
                        state_d     = ST_RUN;
                    end else begin
                        pc_d    = pc_q + 32'd4;
                        state_d = ST_RUN;
                    end
                end
            end
            ST_FLUSH: begin
                if (i_dmem_busy) begin
                    pipe_hold = 1'b1;
                end else begin
                    if_id_en    = 1'b1;
                    if_id_flush = 1'b1;
                    if (i_imem_ready) begin
                        pc_d = pc_q + 32'd4;
                    end else begin
                        pc_d = pc_q;
                    end
                    // A zero count can only come from a corrupted register; leave FLUSH rather than lock up
                    if (flush_cnt_q <= 2'd1) begin
                        flush_cnt_d = 2'd0;
                        state_d     = ST_RUN;
                    end else begin
                        flush_cnt_d = flush_cnt_q - 2'd1;
                        state_d     = ST_FLUSH;
                    end
                end
            end
            default: begin
                state_d = ST_BOOT;
            end
        endcase
    end

    assign pc        = pc_q;
    assign state     = state_q;
    assign stall_err = stall_err_q;

endmodule
